// File: rtl/game_score_keeper_if.sv
// Game-logic side of the score keeper: collision pixels, start/score strobes in; BCD scores, status and LEDs out.
// Combinational wiring only; no handshake, every strobe is taken the cycle it is high.
interface game_score_keeper_if #(
  parameter int DIGITS = 2,
  parameter int LED_W  = 10
);
  logic                  start;
  logic                  bird_color;
  logic                  pipe_color;
  logic                  score_evt;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   high_bcd;
  logic                  game_over;
  logic                  new_high;
  logic [LED_W-1:0]      led;

  modport master (
    output start, bird_color, pipe_color, score_evt,
    input  score_bcd, high_bcd, game_over, new_high, led
  );

  modport slave (
    input  start, bird_color, pipe_color, score_evt,
    output score_bcd, high_bcd, game_over, new_high, led
  );
endinterface

// File: rtl/game_score_keeper.sv
// IDLE/PLAYING/OVER game FSM with debounced collision, saturating BCD score, high-score latch and LED flash.
// All outputs registered (1-cycle latency from inputs); no backpressure, inputs are sampled every cycle.
module game_score_keeper #(
  parameter int DIGITS      = 2,
  parameter int SCORE_MODE  = 0,
  parameter int SCORE_TICKS = 75000000,
  parameter int FLASH_TICKS = 25000000,
  parameter int COLL_CYCLES = 4,
  parameter int LED_W       = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  game_score_keeper_if.slave    bus
);

  localparam int SW = 4 * DIGITS;
  localparam int TW = $clog2(SCORE_TICKS);
  localparam int FW = $clog2(FLASH_TICKS);
  localparam int CW = $clog2(COLL_CYCLES + 1);
  localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_OVER
  } state_t;

  state_t            state;
  logic [SW-1:0]     score;
  logic [SW-1:0]     high;
  logic [TW-1:0]     tick_cnt;
  logic [FW-1:0]     flash_cnt;
  logic [CW-1:0]     coll_cnt;
  logic [LED_W-1:0]  led;
  logic              game_over;
  logic              new_high;

  logic              overlap;
  logic              tick_wrap;
  logic              flash_wrap;
  logic              score_inc;
  logic              coll_hit;
  logic [SW-1:0]     score_next;

  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign overlap    = bus.bird_color & bus.pipe_color;
  assign tick_wrap  = (tick_cnt == TW'(SCORE_TICKS - 1));
  assign flash_wrap = (flash_cnt == FW'(FLASH_TICKS - 1));
  assign score_inc  = (SCORE_MODE == 0) ? tick_wrap : bus.score_evt;
  // Saturate at all-9s rather than rolling over to zero.
  assign score_next = (score_inc && (score != ALL_NINES)) ? bcd_inc(score) : score;
  assign coll_hit   = overlap && (coll_cnt == CW'(COLL_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      score     <= '0;
      high      <= '0;
      tick_cnt  <= '0;
      flash_cnt <= '0;
      coll_cnt  <= '0;
      led       <= '0;
      game_over <= 1'b0;
      new_high  <= 1'b0;
    end else begin
      new_high <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_PLAY;
            score    <= '0;
            tick_cnt <= '0;
            coll_cnt <= '0;
          end
        end
        S_PLAY: begin
          score <= score_next;
          if (SCORE_MODE == 0) begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
          end
          // Packed BCD compares correctly as plain unsigned.
          if (coll_hit) begin
            state     <= S_OVER;
            game_over <= 1'b1;
            coll_cnt  <= '0;
            flash_cnt <= '0;
            led       <= '0;
            if (score_next > high) begin
              high     <= score_next;
              new_high <= 1'b1;
            end
          end else begin
            coll_cnt <= overlap ? coll_cnt + CW'(1) : '0;
          end
        end
        S_OVER: begin
          if (bus.start) begin
            state     <= S_PLAY;
            game_over <= 1'b0;
            score     <= '0;
            tick_cnt  <= '0;
            flash_cnt <= '0;
            led       <= '0;
          end else if (flash_wrap) begin
            flash_cnt <= '0;
            led       <= ~led;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.score_bcd = score;
  assign bus.high_bcd  = high;
  assign bus.game_over = game_over;
  assign bus.new_high  = new_high;
  assign bus.led       = led;

endmodule

// File: tb/tb_game_score_keeper.sv
// Bench for game_score_keeper: one timer-scored and one event-scored instance checked every cycle
// against an integer-score model, plus literal checkpoints from hand-worked game timelines.
module tb_game_score_keeper;

  localparam int DG = 2;
  localparam int LW = 10;
  localparam int ST = 4;
  localparam int FT = 3;
  localparam int CC = 2;
  localparam int MAXS = 99;
  localparam int P_IDLE = 0;
  localparam int P_PLAY = 1;
  localparam int P_OVER = 2;

  logic clk;
  logic reset_n;
  bit   cmp_en;
  int   total;
  int   passed;

  game_score_keeper_if #(.DIGITS(DG), .LED_W(LW)) t_if ();
  game_score_keeper_if #(.DIGITS(DG), .LED_W(LW)) e_if ();

  game_score_keeper #(
    .DIGITS(DG), .SCORE_MODE(0), .SCORE_TICKS(ST),
    .FLASH_TICKS(FT), .COLL_CYCLES(CC), .LED_W(LW)
  ) dut_t (
    .clk(clk), .reset_n(reset_n), .bus(t_if.slave)
  );

  game_score_keeper #(
    .DIGITS(DG), .SCORE_MODE(1), .SCORE_TICKS(ST),
    .FLASH_TICKS(FT), .COLL_CYCLES(CC), .LED_W(LW)
  ) dut_e (
    .clk(clk), .reset_n(reset_n), .bus(e_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: score kept as a plain integer, flashing derived from cycles spent in OVER.
  int m_phase[2];
  int m_score[2];
  int m_high[2];
  int m_run[2];
  int m_tick[2];
  int m_ocyc[2];
  bit m_nh[2];

  task automatic model_step(input int k, input bit st, input bit ovl, input bit evt, input int mode);
    bit inc;
    if (!reset_n) begin
      m_phase[k] = P_IDLE; m_score[k] = 0; m_high[k] = 0; m_run[k] = 0;
      m_tick[k] = 0; m_ocyc[k] = 0; m_nh[k] = 0;
      return;
    end
    m_nh[k] = 0;
    case (m_phase[k])
      P_IDLE: begin
        if (st) begin
          m_phase[k] = P_PLAY; m_score[k] = 0; m_tick[k] = 0; m_run[k] = 0;
        end
      end
      P_PLAY: begin
        if (mode == 0) begin
          inc = (m_tick[k] == ST - 1);
          m_tick[k] = (m_tick[k] + 1) % ST;
        end else begin
          inc = evt;
        end
        if (inc && m_score[k] < MAXS) m_score[k]++;
        m_run[k] = ovl ? m_run[k] + 1 : 0;
        if (m_run[k] == CC) begin
          m_phase[k] = P_OVER; m_run[k] = 0; m_ocyc[k] = 0;
          if (m_score[k] > m_high[k]) begin
            m_high[k] = m_score[k]; m_nh[k] = 1;
          end
        end
      end
      default: begin
        if (st) begin
          m_phase[k] = P_PLAY; m_score[k] = 0; m_tick[k] = 0; m_ocyc[k] = 0;
        end else begin
          m_ocyc[k]++;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cmp_dut(input int k, input string tag, input logic [31:0] sc, input logic [31:0] hi,
                         input logic go, input logic nh, input logic [31:0] ld);
    logic [31:0] exp_led;
    exp_led = (m_phase[k] == P_OVER && ((m_ocyc[k] / FT) % 2) == 1) ? 32'h3FF : 32'h0;
    check({tag, ".score"}, sc, to_bcd(m_score[k]));
    check({tag, ".high"}, hi, to_bcd(m_high[k]));
    check({tag, ".game_over"}, {31'd0, go}, {31'd0, m_phase[k] == P_OVER});
    check({tag, ".new_high"}, {31'd0, nh}, {31'd0, m_nh[k]});
    check({tag, ".led"}, ld, exp_led);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      model_step(0, t_if.start, t_if.bird_color & t_if.pipe_color, t_if.score_evt, 0);
      model_step(1, e_if.start, e_if.bird_color & e_if.pipe_color, e_if.score_evt, 1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        cmp_dut(0, "t", 32'(t_if.score_bcd), 32'(t_if.high_bcd), t_if.game_over, t_if.new_high, 32'(t_if.led));
        cmp_dut(1, "e", 32'(e_if.score_bcd), 32'(e_if.high_bcd), e_if.game_over, e_if.new_high, 32'(e_if.led));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic t_collide();
    t_if.bird_color = 1'b1; t_if.pipe_color = 1'b1;
    cyc(2);
    t_if.bird_color = 1'b0; t_if.pipe_color = 1'b0;
  endtask

  task automatic e_pulse();
    e_if.score_evt = 1'b1; cyc(1);
    e_if.score_evt = 1'b0; cyc(1);
  endtask

  initial begin
    total = 0; passed = 0; cmp_en = 1'b0;
    reset_n = 1'b0;
    t_if.start = 0; t_if.bird_color = 0; t_if.pipe_color = 0; t_if.score_evt = 0;
    e_if.start = 0; e_if.bird_color = 0; e_if.pipe_color = 0; e_if.score_evt = 0;
    cyc(3);
    check("reset.score", 32'(t_if.score_bcd), 32'h0);
    check("reset.led", 32'(t_if.led), 32'h0);
    check("reset.game_over", {31'd0, e_if.game_over}, 32'h0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Game A (timer scoring): 9->10 carry, collision, first high score, flashing.
    t_if.start = 1; cyc(1); t_if.start = 0;
    cyc(36);
    check("A.score_at_36", 32'(t_if.score_bcd), 32'h09);
    cyc(4);
    check("A.score_at_40", 32'(t_if.score_bcd), 32'h10);
    t_collide();
    check("A.game_over", {31'd0, t_if.game_over}, 32'h1);
    check("A.high", 32'(t_if.high_bcd), 32'h10);
    check("A.new_high", {31'd0, t_if.new_high}, 32'h1);
    cyc(1);
    check("A.new_high_gone", {31'd0, t_if.new_high}, 32'h0);
    cyc(2);
    check("A.led_plus3", 32'(t_if.led), 32'h3FF);
    cyc(3);
    check("A.led_plus6", 32'(t_if.led), 32'h0);
    cyc(3);
    check("A.led_plus9", 32'(t_if.led), 32'h3FF);
    check("A.score_frozen", 32'(t_if.score_bcd), 32'h10);

    // Game B: restart clears, single-cycle overlaps never end the game, ends at 07.
    t_if.start = 1; cyc(1); t_if.start = 0;
    check("B.led_cleared", 32'(t_if.led), 32'h0);
    check("B.score_cleared", 32'(t_if.score_bcd), 32'h0);
    for (int i = 0; i < 5; i++) begin
      t_if.bird_color = 1; t_if.pipe_color = 1; cyc(1);
      t_if.pipe_color = 0; cyc(1);
    end
    t_if.bird_color = 0;
    check("B.not_over", {31'd0, t_if.game_over}, 32'h0);
    cyc(18);
    t_collide();
    check("B.final", 32'(t_if.score_bcd), 32'h07);
    check("B.high_kept", 32'(t_if.high_bcd), 32'h10);
    check("B.no_pulse", {31'd0, t_if.new_high}, 32'h0);

    // Game C: tie with the high score does not replace it.
    t_if.start = 1; cyc(1); t_if.start = 0;
    cyc(40);
    t_collide();
    check("C.final", 32'(t_if.score_bcd), 32'h10);
    check("C.no_pulse", {31'd0, t_if.new_high}, 32'h0);

    // Event scoring: ignored in IDLE, same-edge increment+collision, saturation.
    e_if.score_evt = 1; cyc(3); e_if.score_evt = 0;
    check("E.idle_evt", 32'(e_if.score_bcd), 32'h0);
    e_if.start = 1; cyc(1); e_if.start = 0;
    for (int i = 0; i < 3; i++) e_pulse();
    e_if.bird_color = 1; e_if.pipe_color = 1; cyc(1);
    e_if.score_evt = 1; cyc(1);
    e_if.score_evt = 0; e_if.bird_color = 0; e_if.pipe_color = 0;
    check("E1.final", 32'(e_if.score_bcd), 32'h04);
    check("E1.high", 32'(e_if.high_bcd), 32'h04);
    check("E1.new_high", {31'd0, e_if.new_high}, 32'h1);
    e_if.score_evt = 1; cyc(3); e_if.score_evt = 0;
    check("E1.over_evt", 32'(e_if.score_bcd), 32'h04);
    e_if.start = 1; cyc(1); e_if.start = 0;
    for (int i = 0; i < 105; i++) begin
      e_pulse();
      if (i == 9) check("E2.score_10", 32'(e_if.score_bcd), 32'h10);
    end
    check("E2.saturated", 32'(e_if.score_bcd), 32'h99);
    e_if.bird_color = 1; e_if.pipe_color = 1; cyc(2);
    e_if.bird_color = 0; e_if.pipe_color = 0;
    check("E2.high", 32'(e_if.high_bcd), 32'h99);

    // Reset mid-game wipes everything asynchronously, including the high score.
    t_if.start = 1; cyc(1); t_if.start = 0;
    cyc(10);
    check("D.score_before_reset", 32'(t_if.score_bcd), 32'h02);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("D.async_score", 32'(t_if.score_bcd), 32'h0);
    check("D.async_high", 32'(t_if.high_bcd), 32'h0);
    check("D.async_e_high", 32'(e_if.high_bcd), 32'h0);
    check("D.async_led", 32'(e_if.led), 32'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(8);
    check("D.idle_no_score", 32'(t_if.score_bcd), 32'h0);
    t_if.start = 1; cyc(1); t_if.start = 0;
    cyc(4);
    check("D.first_tick", 32'(t_if.score_bcd), 32'h01);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
